// File: rtl/microtile_arb_pkg.sv
// Shared types and defaults for the microtile output arbiter.
package microtile_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam int GAP_CYCLES_DEF = 1;
  localparam int MAX_HOLD_DEF   = 16;

  // Gap counter width covers GAP_CYCLES up to 15.
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/microtile_out_arbiter_if.sv
// Bus between the microtile outputs and the shared uo_out pad arbiter.
//
// Handshake: req[i] is a level request owned by tile i. gnt[i] high means
// tile i owns the pads; the tile keeps req[i] high for as long as it wants
// them and drops req[i] for at least one cycle to release. There is no
// per-beat ready: while granted, req_data[8i+7:8i] is taken every cycle.
// state is a read-only view of the arbiter FSM for debug and checkers.
interface microtile_out_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import microtile_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic                 ena;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic                 busy;
  logic [7:0]           uo_out;
  arb_state_e           state;

  // Tile / wrapper side.
  modport master (
    output ena, req, req_data,
    input  gnt, gnt_id, busy, uo_out, state
  );

  // Arbiter side.
  modport slave (
    input  ena, req, req_data,
    output gnt, gnt_id, busy, uo_out, state
  );

endinterface

// File: rtl/microtile_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1, wrapping modulo NUM_REQ. ptr itself is checked last.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  logic [ID_W-1:0] cand;

  // Scan candidates in priority order and keep the first requester.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/microtile_out_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit uo_out pad bus.
// One tile owns the pads at a time; its byte reaches uo_out through one
// register stage. A GAP_CYCLES idle gap follows every release.
// Optional feature macro: MICROTILE_ARB_TIMEOUT_EN (grant length limited
// to MAX_HOLD cycles; a forcibly released tile is masked until it drops req).
module microtile_out_arbiter
  import microtile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int MAX_HOLD   = MAX_HOLD_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  microtile_out_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  // The gap counter is loaded with GAP_CYCLES-1 and exits GAP at zero.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : GAP_CNT_W'(GAP_CYCLES - 1);

  arb_state_e             state, state_nxt;
  logic [NUM_REQ-1:0]     gnt_q, gnt_nxt;
  logic [ID_W-1:0]        id_q, id_nxt;
  logic                   busy_q, busy_nxt;
  logic [7:0]             uo_q, uo_nxt;
  logic [ID_W-1:0]        last_q, last_nxt;
  logic [GAP_CNT_W-1:0]   gap_q, gap_nxt;

  logic [7:0]             data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]     req_elig;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_found;
  logic                   owner_held;
  logic                   timeout;

`ifdef MICROTILE_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  hold_q, hold_nxt;
  logic [NUM_REQ-1:0] mask_q, mask_nxt;

  assign req_elig = bus.req & ~mask_q;
  assign timeout  = (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
  assign req_elig = bus.req;
  assign timeout  = 1'b0;
`endif

  // Unpack the flat per-tile byte bus for indexed selection.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = bus.req_data[8*i +: 8];
    end
  end

  assign owner_held = bus.req[id_q];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_elig),
    .ptr    (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Next-state and next-output logic; uo_out only carries data while the
  // owner keeps the grant, so a release edge already shows 0.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    busy_nxt  = busy_q;
    uo_nxt    = 8'd0;
    last_nxt  = last_q;
    gap_nxt   = gap_q;
`ifdef MICROTILE_ARB_TIMEOUT_EN
    hold_nxt  = hold_q;
    // A masked tile becomes eligible again once it has dropped req.
    mask_nxt  = mask_q & bus.req;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.ena && pick_found) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = pick_onehot;
          id_nxt    = pick_idx;
          busy_nxt  = 1'b1;
          last_nxt  = pick_idx;
`ifdef MICROTILE_ARB_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!owner_held || !bus.ena || timeout) begin
          state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          gap_nxt   = GAP_LOAD;
`ifdef MICROTILE_ARB_TIMEOUT_EN
          if (timeout && owner_held) begin
            mask_nxt[id_q] = 1'b1;
          end
`endif
        end else begin
          uo_nxt = data_arr[id_q];
`ifdef MICROTILE_ARB_TIMEOUT_EN
          hold_nxt = hold_q + HOLD_W'(1);
`endif
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_q - GAP_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      id_q   <= '0;
      busy_q <= 1'b0;
      uo_q   <= 8'd0;
      last_q <= ID_W'(NUM_REQ - 1);
      gap_q  <= '0;
`ifdef MICROTILE_ARB_TIMEOUT_EN
      hold_q <= '0;
      mask_q <= '0;
`endif
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      id_q   <= id_nxt;
      busy_q <= busy_nxt;
      uo_q   <= uo_nxt;
      last_q <= last_nxt;
      gap_q  <= gap_nxt;
`ifdef MICROTILE_ARB_TIMEOUT_EN
      hold_q <= hold_nxt;
      mask_q <= mask_nxt;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = id_q;
  assign bus.busy   = busy_q;
  assign bus.uo_out = uo_q;
  assign bus.state  = state;

endmodule

// File: tb/tb_microtile_out_arbiter.sv
// Self-checking bench for microtile_out_arbiter (NUM_REQ=4, GAP_CYCLES=2,
// MAX_HOLD=16). Directed scenarios followed by randomized request traffic,
// all checked against a behavioural owner/cooldown model.
// Honors MICROTILE_ARB_TIMEOUT_EN when the bench and RTL are built with it.
module tb_microtile_out_arbiter;
  import microtile_arb_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int GAP      = 2;
  localparam int MAX_HOLD = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  microtile_out_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  microtile_out_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .GAP_CYCLES (GAP),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int                 m_owner;  // -1 when nobody owns the pads
  int                 m_cool;   // idle-gap cycles still to run
  int                 m_ptr;    // last winner
  int                 m_held;   // grant cycles so far for current owner
  bit [NUM_REQ-1:0]   m_block;  // tiles cut off by the hold limit
  logic [7:0]         exp_q[$]; // expected uo_out, one per edge

  task automatic model_reset();
    m_owner = -1;
    m_cool  = 0;
    m_ptr   = NUM_REQ - 1;
    m_held  = 0;
    m_block = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [NUM_REQ-1:0] r, input logic e,
                            input logic [8*NUM_REQ-1:0] d);
    logic [7:0] uo;
    bit         timed;
    int         w;
    int         cut;
    uo    = 8'd0;
    timed = 1'b0;
    cut   = -1;
    if (m_owner >= 0) begin
`ifdef MICROTILE_ARB_TIMEOUT_EN
      timed = (m_held >= MAX_HOLD);
`endif
      if (r[m_owner] && e && !timed) begin
        uo = d[8*m_owner +: 8];
        m_held++;
      end else begin
        if (timed && r[m_owner]) cut = m_owner;
        m_owner = -1;
        m_cool  = GAP;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (e) begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (w < 0 && r[c] && !m_block[c]) w = c;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_held  = 1;
      end
    end
    m_block = m_block & r;
    if (cut >= 0) m_block[cut] = 1'b1;
    exp_q.push_back(uo);
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NUM_REQ-1:0] r, input logic e);
    bus.req = r;
    bus.ena = e;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[8*i +: 8] = 8'($urandom);
  endtask

  // One clock edge: advance the model with the sampled inputs, then compare.
  task automatic tick();
    logic [31:0] exp_st;
    @(posedge clk);
    model_step(bus.req, bus.ena, bus.req_data);
    #1;
    if (m_owner >= 0)   exp_st = 32'(ST_GRANT);
    else if (m_cool > 0) exp_st = 32'(ST_GAP);
    else                 exp_st = 32'(ST_IDLE);
    check_val("gnt", bus.gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
    check_val("busy", bus.busy, (m_owner >= 0) ? 1 : 0);
    if (m_owner >= 0) check_val("gnt_id", bus.gnt_id, m_owner);
    check_val("uo_out", bus.uo_out, exp_q.pop_front());
    check_val("state", bus.state, exp_st);
  endtask

  task automatic wait_busy(input logic [NUM_REQ-1:0] r, input string tag);
    logic got;
    got = 1'b0;
    for (int w = 0; w < 12 && !got; w++) begin
      drive(r, 1'b1);
      tick();
      got = bus.busy;
    end
    check_val(tag, got, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]         d1;
    logic [NUM_REQ-1:0] cur;
    logic [NUM_REQ-1:0] rel;
    int                 cnt;

    model_reset();
    drive('0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("rst_gnt", bus.gnt, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_gnt_id", bus.gnt_id, 0);
    check_val("rst_uo", bus.uo_out, 0);
    check_val("rst_state", bus.state, 32'(ST_IDLE));
    rst_n = 1'b1;

    // Simultaneous requests from a fresh pointer: tile 1 wins over 2.
    drive(4'b0110, 1'b1);
    tick();
    check_val("t1_gnt", bus.gnt, 4'b0010);
    check_val("t1_first_uo", bus.uo_out, 0);
    drive(4'b0110, 1'b1);
    d1 = bus.req_data[15:8];
    tick();
    check_val("t1_data", bus.uo_out, d1);
    repeat (3) begin drive(4'b0110, 1'b1); tick(); end

    // Tile 1 releases with 0 and 2 pending: gap, one idle cycle, then tile 2.
    drive(4'b0101, 1'b1);
    tick();
    check_val("t2_rel_gnt", bus.gnt, 0);
    check_val("t2_rel_uo", bus.uo_out, 0);
    repeat (2) begin
      drive(4'b0101, 1'b1);
      tick();
      check_val("t2_gap_gnt", bus.gnt, 0);
    end
    drive(4'b0101, 1'b1);
    tick();
    check_val("t2_next", bus.gnt, 4'b0100);
    repeat (6) begin drive(4'b0000, 1'b1); tick(); end

    // Fresh reset, then all four request; each releases after 3 cycles.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cur = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_busy(cur, "t3_seen");
      check_val("t3_order", bus.gnt_id, g % NUM_REQ);
      repeat (2) begin drive(cur, 1'b1); tick(); end
      rel = cur;
      rel[g % NUM_REQ] = 1'b0;
      drive(rel, 1'b1);
      tick();
    end

    // ena dropped mid-grant.
    wait_busy(4'b1111, "t4_seen");
    drive(4'b1111, 1'b0);
    tick();
    check_val("t4_gnt", bus.gnt, 0);
    check_val("t4_uo", bus.uo_out, 0);
    repeat (8) begin
      drive(4'b1111, 1'b0);
      tick();
      check_val("t4_idle", bus.busy, 0);
    end
    wait_busy(4'b1111, "t4_resume");

    // Reset pulsed while tile 2 owns the bus.
    cnt = 0;
    for (int w = 0; w < 24; w++) begin
      drive(4'b0100, 1'b1);
      tick();
      if (bus.busy && bus.gnt_id == 2) break;
    end
    check_val("t5_own", bus.gnt, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_gnt", bus.gnt, 0);
    check_val("t5_rst_busy", bus.busy, 0);
    check_val("t5_rst_uo", bus.uo_out, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b1);
    tick();
    check_val("t5_first", bus.gnt, 4'b0001);

    // Tile 0 keeps requesting.
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      drive(4'b0001, 1'b1);
      tick();
      if (bus.gnt[0]) cnt++;
      else break;
    end
`ifdef MICROTILE_ARB_TIMEOUT_EN
    check_val("t6_len", cnt, MAX_HOLD);
    repeat (10) begin
      drive(4'b0001, 1'b1);
      tick();
      check_val("t6_masked", bus.busy, 0);
    end
    drive(4'b0000, 1'b1);
    tick();
    wait_busy(4'b0001, "t6_regrant");
`else
    check_val("t6_held", cnt, 41);
`endif
    repeat (4) begin drive(4'b0000, 1'b1); tick(); end

    // Randomized traffic.
    cur = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cur[i]) cur[i] = ($urandom_range(0, 5) != 0);
        else        cur[i] = ($urandom_range(0, 2) == 0);
      end
      drive(cur, ($urandom_range(0, 39) != 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/microtile_out_arbiter.md
# microtile_out_arbiter

Round-robin arbiter that shares one 8-bit `uo_out` pad bus among `NUM_REQ` microtile designs. Each tile raises a request and holds it for as long as it needs the pads. The arbiter grants exactly one tile at a time and drives that tile's data onto `uo_out` through one register stage. A programmable idle gap separates consecutive owners. The block sits between the tile outputs and the top-level `uo_out` of the `tt_um_*` wrapper.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting tiles, range 2..8.
- `GAP_CYCLES`, default 1: forced idle cycles after each release, range 0..15.
- `MAX_HOLD`, default 16: maximum grant length in cycles. Used only when the timeout feature is compiled in.

Ports:
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: arbiter enable. Low means release all owners and grant nothing.
- `req`, input, `NUM_REQ`: per-tile request. Level-sensitive; the tile holds it high while it owns the bus.
- `req_data`, input, `8*NUM_REQ`: per-tile output byte. Tile i uses bits `[8i+7:8i]`.
- `gnt`, output, `NUM_REQ`: one-hot grant, registered.
- `gnt_id`, output, `$clog2(NUM_REQ)`: index of the current owner. Valid while `busy` is high.
- `busy`, output, 1: high while in the GRANT state.
- `uo_out`, output, 8: registered copy of the owner's `req_data`. Zero when there is no owner.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: one tile owns the bus.
  - GAP: counting down the idle gap after a release.
- IDLE → GRANT: when `ena` is high and any `req` bit is high. The winner is the first requester searching upward from `last_id+1`, modulo `NUM_REQ`. `last_id` is then updated to the winner.
- GRANT → GAP: when `req[gnt_id]` drops, or `ena` drops, or the hold timeout fires (see Configuration). If `GAP_CYCLES` is 0, go to IDLE instead.
- GAP → IDLE: after `GAP_CYCLES` cycles in GAP.
- Requests seen in GAP are ignored. Arbitration happens only in IDLE.
- If the owner drops `req` and raises it again in the same cycle, that counts as still held. A tile must drop `req` for at least one cycle to release.
- Requests from other tiles never preempt the current owner.
- `uo_out` register: loads `req_data[gnt_id]` each cycle in GRANT, and loads 0 in IDLE and GAP.
- Reset values:
  - state = IDLE
  - `gnt` = 0, `gnt_id` = 0, `busy` = 0, `uo_out` = 0
  - `last_id` = `NUM_REQ-1`, so tile 0 wins the first arbitration
  - gap counter = 0, hold counter = 0
- Reset asserted mid-grant: all outputs clear immediately (asynchronous). After release, arbitration restarts from tile 0.

## Timing
- Request to grant: a `req` seen high at edge t in IDLE gives `gnt`/`busy` high after edge t, i.e. one cycle.
- Data latency: `uo_out` after edge k equals `req_data[gnt_id]` sampled at edge k, so it trails the grant by one cycle. The first grant cycle shows 0.
- Release: `req` low seen at edge r makes `gnt` = 0 and `uo_out` = 0 after edge r.
- After release, the earliest next grant is `GAP_CYCLES + 1` cycles later (IDLE takes one cycle to arbitrate). With `GAP_CYCLES`=0, the bus is back-to-back with one IDLE cycle.
- Simultaneous requests in IDLE: decided solely by the round-robin pointer.

## Configuration
- Macro `MICROTILE_ARB_TIMEOUT_EN`.
- When defined:
  - The hold counter clears on entry to GRANT and increments every GRANT cycle.
  - When the count reaches `MAX_HOLD-1`, the arbiter forces GRANT → GAP even if `req` is still high.
  - A tile whose grant was forcibly ended must drop `req` for one cycle before it is eligible again; it is masked until then.
- When undefined: no hold counter and no mask logic. A grant lasts until the owner releases it or `ena` drops. `MAX_HOLD` is ignored.

## Structure
- Package `microtile_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_GRANT`, `ST_GAP`)
  - the default constants for `GAP_CYCLES` and `MAX_HOLD`
- Sub-module `rr_pick`: a combinational round-robin picker. Inputs are the request vector and the pointer; outputs are a one-hot result, its index, and a found flag.
- The top module holds the FSM, the counters, and the output register.

## Test plan
- Reset, then `req`=4'b0110 → `gnt`=4'b0010 one cycle later; `uo_out` = `req_data[1]` one cycle after that.
- Tile 1 releases while `req`=4'b0101 is pending, `GAP_CYCLES`=2 → two cycles with `uo_out`=0, one IDLE cycle, then `gnt`=4'b0100.
- All four tiles request continuously, each releasing after 3 cycles → grant order 0,1,2,3,0.
- `ena` dropped mid-grant → `gnt`=0 and `uo_out`=0 next cycle; no new grant until `ena` returns high.
- `rst_n` pulsed low during grant of tile 2 → outputs zero immediately; the next arbitration with `req`=4'b1111 grants tile 0.
- With `MICROTILE_ARB_TIMEOUT_EN` and `MAX_HOLD`=16: tile 0 holds `req` high → forced release after 16 grant cycles; tile 0 is not re-granted until it toggles `req` low.
